// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore-style multi-cycle sequencer for the RV32 subset datapath
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       pc_src,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WB   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_ALU_WB   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic             waiting;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    trap_d  = trap_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          7'b0110011:             state_d = S_EXEC_R;
          7'b0010011:             state_d = S_EXEC_I;
          7'b0000011, 7'b0100011: state_d = S_MEM_ADDR;
          7'b1100011:             state_d = S_BRANCH;
          default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = 2'b01;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I:               state_d = S_ALU_WB;
      S_MEM_ADDR:                       state_d = opcode[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready)        state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready)        state_d = S_FETCH;
      S_MEM_WB, S_ALU_WB, S_BRANCH:     state_d = S_FETCH;
      S_TRAP:                           state_d = S_TRAP;
      default:                          state_d = S_FETCH;
    endcase
    // An unanswered request on the last allowed wait cycle traps; mem_ready in that cycle still wins.
    if (waiting && !mem_ready) begin
      if (cnt_q == CNT_LAST) begin
        state_d = S_TRAP;
        trap_d  = 1'b1;
        cause_d = 2'b10;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: mem_read = 1'b1;
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b01;
        alu_op     = 2'b01;
        pc_src     = 1'b1;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Held in reset, the datapath sees no enables or requests even though the state already reads FETCH.
    if (!rst_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      pc_src     = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench with an instruction-level timing model
module tb_multicycle_ctrl;
  localparam int MAX = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, pc_src, instr_done, trap;
  logic [1:0] alu_src_a, alu_src_b, alu_op, trap_cause;
  logic [3:0] state_o;

  multicycle_ctrl #(.MEM_WAIT_MAX(MAX), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .pc_src(pc_src), .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, irw, rw;
    logic [1:0] a, b, op;
    logic mr, mw, m2r, ps, done, trp;
    logic [1:0] cause;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    m_st = 0, m_trap = 0, m_cause = 0;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BEQ = 7'b1100011;

  function automatic exp_t mk(input int st, pcw, irw, rw, a, b, op, mr, mw, m2r, ps, done, trp, cause);
    exp_t e;
    e.st = st[3:0]; e.pcw = pcw[0]; e.irw = irw[0]; e.rw = rw[0];
    e.a = a[1:0]; e.b = b[1:0]; e.op = op[1:0];
    e.mr = mr[0]; e.mw = mw[0]; e.m2r = m2r[0]; e.ps = ps[0]; e.done = done[0];
    e.trp = trp[0]; e.cause = cause[1:0];
    return e;
  endfunction

  task automatic step(input logic r, input logic [6:0] o, input logic z, input logic rdy,
                      input exp_t e, input string tag);
    rst_n = r; opcode = o; zero = z; mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    m_st = int'(e.st); m_trap = int'(e.trp); m_cause = int'(e.cause);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    step(1'b0, 7'($urandom), 1'($urandom), 1'($urandom),
         mk(m_st, 0,0,0, 0,0,0, 0,0,0,0,0, m_trap, m_cause), "reset_entry");
    for (int i = 1; i < n; i++)
      step(1'b0, 7'($urandom), 1'($urandom), 1'($urandom),
           mk(0, 0,0,0, 0,0,0, 0,0,0,0,0, 0,0), "reset_hold");
  endtask

  task automatic hold_trap(input int n, input int cause, input logic [6:0] op);
    for (int i = 0; i < n; i++)
      step(1'b1, op, 1'($urandom), 1'($urandom),
           mk(10, 0,0,0, 0,0,0, 0,0,0,0,0, 1,cause), "trap_hold");
  endtask

  // Wait phase of a memory request: w idle cycles then completion, or MAX idle cycles then trap.
  task automatic mem_wait(input int st, input int w, input logic [6:0] op, output bit trapped);
    trapped = 0;
    for (int i = 0; i < w && i < MAX; i++)
      step(1'b1, op, 1'($urandom), 1'b0,
           mk(st, 0,0,0, 0,(st == 0) ? 1 : 0,0, (st != 7) ? 1 : 0,(st == 7) ? 1 : 0,0,0,0, 0,0),
           "mem_wait");
    if (w >= MAX) begin
      trapped = 1;
      hold_trap(4 + int'($urandom_range(0, 3)), 2, op);
      do_reset(2);
    end
  endtask

  function automatic bit legal(input logic [6:0] op);
    return op == OP_R || op == OP_I || op == OP_LW || op == OP_SW || op == OP_BEQ;
  endfunction

  task automatic issue(input logic [6:0] op, input logic z, input int wf, input int wm, input bit abort);
    bit tr;
    mem_wait(0, wf, 7'($urandom), tr);
    if (tr) return;
    step(1'b1, 7'($urandom), 1'($urandom), 1'b1, mk(0, 1,1,0, 0,1,0, 1,0,0,0,0, 0,0), "fetch_done");
    step(1'b1, op, 1'($urandom), 1'($urandom), mk(1, 0,0,0, 2,2,0, 0,0,0,0,0, 0,0), "decode");
    if (!legal(op)) begin
      hold_trap(20, 1, op);
      do_reset(2);
      return;
    end
    case (op)
      OP_R, OP_I: begin
        if (op == OP_R) step(1'b1, op, 1'($urandom), 1'($urandom), mk(2, 0,0,0, 1,0,2, 0,0,0,0,0, 0,0), "exec_r");
        else            step(1'b1, op, 1'($urandom), 1'($urandom), mk(3, 0,0,0, 1,2,3, 0,0,0,0,0, 0,0), "exec_i");
        step(1'b1, op, 1'($urandom), 1'($urandom), mk(8, 0,0,1, 0,0,0, 0,0,0,0,1, 0,0), "alu_wb");
      end
      OP_LW, OP_SW: begin
        step(1'b1, op, 1'($urandom), 1'($urandom), mk(4, 0,0,0, 1,2,0, 0,0,0,0,0, 0,0), "mem_addr");
        mem_wait((op == OP_LW) ? 5 : 7, abort ? MAX + 1 : wm, op, tr);
        if (tr) return;
        if (abort) begin
          do_reset(2);
          return;
        end
        if (op == OP_LW) begin
          step(1'b1, op, 1'($urandom), 1'b1, mk(5, 0,0,0, 0,0,0, 1,0,0,0,0, 0,0), "mem_rd_done");
          step(1'b1, op, 1'($urandom), 1'($urandom), mk(6, 0,0,1, 0,0,0, 0,0,1,0,1, 0,0), "mem_wb");
        end else begin
          step(1'b1, op, 1'($urandom), 1'b1, mk(7, 0,0,0, 0,0,0, 0,1,0,0,1, 0,0), "mem_wr_done");
        end
      end
      default:
        step(1'b1, op, z, 1'($urandom), mk(9, int'(z),0,0, 1,0,1, 0,0,0,1,1, 0,0), "branch");
    endcase
  endtask

  // Mid-store reset: a few unanswered write cycles, then reset lands while still waiting.
  task automatic sw_abort(input int w);
    bit tr;
    mem_wait(0, 0, 7'($urandom), tr);
    step(1'b1, 7'($urandom), 1'($urandom), 1'b1, mk(0, 1,1,0, 0,1,0, 1,0,0,0,0, 0,0), "fetch_done");
    step(1'b1, OP_SW, 1'($urandom), 1'($urandom), mk(1, 0,0,0, 2,2,0, 0,0,0,0,0, 0,0), "decode");
    step(1'b1, OP_SW, 1'($urandom), 1'($urandom), mk(4, 0,0,0, 1,2,0, 0,0,0,0,0, 0,0), "mem_addr");
    mem_wait(7, w, OP_SW, tr);
    do_reset(2);
  endtask

  always @(negedge clk) begin
    exp_t e, act;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      act.st = state_o; act.pcw = pc_write; act.irw = ir_write; act.rw = reg_write;
      act.a = alu_src_a; act.b = alu_src_b; act.op = alu_op;
      act.mr = mem_read; act.mw = mem_write; act.m2r = mem_to_reg; act.ps = pc_src;
      act.done = instr_done; act.trp = trap; act.cause = trap_cause;
      n_vec++;
      if (act !== e) begin
        n_err++;
        $display("FAIL %s @%0t: actual st=%0d vec=%b, required st=%0d vec=%b",
                 t, $time, act.st, act, e.st, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, %0d expectations pending", exp_q.size());
    $fatal(1);
  end

  initial begin
    logic [6:0] op;
    int k;
    rst_n = 1'b0;
    @(posedge clk); #1;
    do_reset(2);

    issue(OP_R, 1'b0, 0, 0, 0);
    issue(OP_LW, 1'b0, 0, 3, 0);
    issue(OP_BEQ, 1'b1, 0, 0, 0);
    issue(OP_BEQ, 1'b0, 0, 0, 0);
    issue(OP_I, 1'b0, 2, 0, 0);
    issue(OP_SW, 1'b0, 1, 2, 0);
    issue(7'b1111111, 1'b0, 0, 0, 0);
    issue(OP_R, 1'b0, MAX, 0, 0);
    issue(OP_R, 1'b0, MAX - 1, 0, 0);
    issue(OP_LW, 1'b0, 0, MAX - 1, 0);
    issue(OP_SW, 1'b0, 0, MAX, 0);
    sw_abort(3);
    issue(OP_I, 1'b0, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1, 9: op = OP_R;
        2, 3:    op = OP_I;
        4:       op = OP_LW;
        5:       op = OP_SW;
        6, 7:    op = OP_BEQ;
        default: begin
          op = 7'($urandom);
          while (legal(op)) op = 7'($urandom);
        end
      endcase
      issue(op, 1'($urandom), int'($urandom_range(0, 3)),
            ($urandom_range(0, 19) == 0) ? MAX : int'($urandom_range(0, 4)), 0);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: actual pending=%0d, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32 subset datapath: R-type, I-type ALU, LW, SW, BEQ.
- Replaces single-cycle decode with a Moore FSM. The FSM steps each instruction through fetch, decode, execute, memory and writeback, sharing one ALU and one memory port.
- Handles variable-latency memory through a ready handshake with timeout.
- Traps on illegal opcodes and on memory timeouts.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles a memory access may wait for mem_ready before a timeout trap. Range 1..255.
- CNT_W, 8: width of the wait counter. Must hold MEM_WAIT_MAX.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- opcode  in  7  instruction register bits [6:0]; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  load PC
- ir_write  out  1  load instruction register
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00=PC, 01=rs1, 10=old PC
- alu_src_b  out  2  00=rs2, 01=const 4, 10=immediate
- alu_op  out  2  00=add, 01=sub/compare, 10=R-funct, 11=I-funct
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_to_reg  out  1  writeback source: 1=memory data, 0=ALU result register
- pc_src  out  1  0=ALU result, 1=ALU-out register (branch target)
- instr_done  out  1  one-cycle pulse when an instruction retires
- trap  out  1  sticky fault indicator
- trap_cause  out  2  00=none, 01=illegal opcode, 10=memory timeout
- state_o  out  4  current state encoding, for debug and verification

Behaviour:
- Reset: a clock edge with rst_n=0 forces
  - state=FETCH, wait counter=0, trap=0, trap_cause=00;
  - all enables 0, all selects 00, instr_done=0.
  - Reset applies from any state, including mid-access and TRAP. Memory requests drop in the next cycle.
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, ALU_WB=8, BRANCH=9, TRAP=10.
- Outputs are decoded from the state only, except pc_write/ir_write in FETCH and pc_write in BRANCH. Any output not listed for a state is 0.
- FETCH: mem_read=1, a=00, b=01, op=00.
  - If mem_ready=1: pc_write=1, ir_write=1, go to DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE: a=10, b=10, op=00 (branch target latched into ALU-out). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - any other opcode -> TRAP, cause 01
- EXEC_R: a=01, b=00, op=10. Then ALU_WB.
- EXEC_I: a=01, b=10, op=11. Then ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, instr_done=1. Then FETCH.
- MEM_ADDR: a=01, b=10, op=00. Go to MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_read=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1. Then FETCH.
- MEM_WR: mem_write=1. Wait for mem_ready; on that cycle instr_done=1, then FETCH.
- BRANCH: a=01, b=00, op=01, pc_src=1, pc_write=zero, instr_done=1. Then FETCH.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Cleared on entry to any of these states and on mem_ready.
  - If mem_ready=0 in the cycle where the counter == MEM_WAIT_MAX-1, go to TRAP with cause 10. This gives exactly MEM_WAIT_MAX request cycles before the trap.
  - mem_ready=1 in that same final cycle wins: the access completes, no trap.
- mem_ready while not requesting memory is ignored.
- TRAP: trap=1 and cause held. All enables 0, no memory requests. Only rst_n=0 exits TRAP.
- Timing per instruction, with mem_ready=1 on first request cycle: R/I = 4 cycles, LW = 5, SW = 4, BEQ = 3.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> state_o=0, all outputs 0, trap=0. The first cycle after release asserts mem_read=1 with a=00, b=01.
- R-type: opcode=0110011, mem_ready always 1 -> state_o sequence 0,1,2,8,0. reg_write=1 and instr_done=1 only in state 8, alu_op=10 in state 2.
- LW with 3 wait cycles in MEM_RD: opcode=0000011 -> states 0,1,4,5,5,5,5,6,0. mem_read=1 throughout state 5, mem_to_reg=1 and reg_write=1 in state 6, no trap.
- BEQ: opcode=1100011, run twice with zero=1 then zero=0 -> pc_write=1 in state 9 only when zero=1. pc_src=1 in both runs, 3 cycles each.
- Illegal and timeout cases:
  - opcode=1111111 -> TRAP after DECODE, trap_cause=01, stays in TRAP for 20 cycles.
  - Separately, mem_ready held 0 in FETCH with MEM_WAIT_MAX=15 -> TRAP after exactly 15 request cycles, cause=10.
  - Separately, mem_ready=1 on the 15th cycle -> no trap.
- Reset mid-operation: assert rst_n=0 during MEM_WR while waiting -> next cycle state_o=0 and mem_write=0. Reset from TRAP clears trap and trap_cause.
